// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// Magnitudes are processed for WIDTH cycles, then signs are fixed up in one extra cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, next_state;

    logic [1:0]         op_r;
    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b, a_raw;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic               in_signed, in_a_neg, in_b_neg, start_dbz;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mult_next, div_next, prod;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff, quot, rem, quot_fix, rem_fix;
    logic               div_fits, res_signed;

    assign in_signed = ~op[0];
    assign in_a_neg  = in_signed & a[WIDTH-1];
    assign in_b_neg  = in_signed & b[WIDTH-1];
    assign abs_a     = in_a_neg ? -a : a;
    assign abs_b     = in_b_neg ? -b : b;
    assign start_dbz = op[1] && (b == '0);

    // Multiply keeps {partial product, remaining multiplier bits} in acc.
    assign add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    assign mult_next = acc[0] ? {add_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Divide keeps {partial remainder, dividend/quotient bits} in acc.
    assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_fits  = rem_shift >= {1'b0, mag_b};
    assign rem_diff  = rem_shift[WIDTH-1:0] - mag_b;
    assign div_next  = div_fits ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                                : {acc[2*WIDTH-2:0], 1'b0};

    assign res_signed = ~op_r[0];
    assign prod       = (res_signed && (sa ^ sb)) ? -acc : acc;
    assign quot       = acc[WIDTH-1:0];
    assign rem        = acc[2*WIDTH-1:WIDTH];
    assign quot_fix   = (res_signed && (sa ^ sb)) ? -quot : quot;
    assign rem_fix    = (res_signed && sa) ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = start_dbz ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == LAST) begin
                    next_state = FIX;
                end
            end
            FIX:  next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            a_raw       <= '0;
            acc         <= '0;
            count       <= '0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r        <= op;
                        sa          <= in_a_neg;
                        sb          <= in_b_neg;
                        mag_a       <= abs_a;
                        mag_b       <= abs_b;
                        a_raw       <= a;
                        count       <= '0;
                        div_by_zero <= start_dbz;
                        acc         <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    acc   <= op_r[1] ? div_next : mult_next;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (div_by_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else if (op_r[1]) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results, a monitor
// compares hi/lo/div_by_zero and start-to-done latency whenever done pulses.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          start_edge;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done_prev = 1'b0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done) begin
                checkOutput("done_pulse_width", {63'b0, done_prev}, 64'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("hi", hi, mon_e.hi);
                    checkOutput("lo", lo, mon_e.lo);
                    checkOutput("div_by_zero", {63'b0, div_by_zero}, {63'b0, mon_e.dbz});
                    checkOutput("latency", 64'(cyc - mon_e.start_edge), 64'(mon_e.lat));
                end
            end
            done_prev = done;
        end
    end

    task automatic issueOp(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] eh, input logic [31:0] el, input logic ed,
                           input int lat, input logic with_mt);
        exp_t e;
        @(negedge clk);
        op    = o;
        a     = av;
        b     = bv;
        start = 1'b1;
        mthi  = with_mt;
        mtlo  = with_mt;
        e.hi = eh; e.lo = el; e.dbz = ed; e.start_edge = cyc + 1; e.lat = lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        checkOutput("busy_after_start", {63'b0, busy}, 64'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: got no done within 100 cycles, expected done");
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] eh, input logic [31:0] el, input logic ed,
                                 input int lat);
        issueOp(o, av, bv, eh, el, ed, lat, 1'b0);
        waitIdle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_hi", hi, 64'd0);
        checkOutput("reset_lo", lo, 64'd0);
        checkOutput("reset_busy", {63'b0, busy}, 64'd0);
        checkOutput("reset_done", {63'b0, done}, 64'd0);
        checkOutput("reset_dbz", {63'b0, div_by_zero}, 64'd0);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        applyStimulus(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        applyStimulus(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0, 33);
        applyStimulus(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        applyStimulus(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);

        applyStimulus(OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1);
        checkOutput("dbz_holds", {63'b0, div_by_zero}, 64'd1);

        applyStimulus(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        applyStimulus(OP_DIVU,  32'd17,       32'd5,        32'd2,        32'd3,        1'b0, 33);

        // Requests while busy must not disturb the running multiply or hi/lo.
        issueOp(OP_MULTU, 32'h10, 32'h10, 32'h0, 32'h100, 1'b0, 33, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("run_hi_untouched", hi, 64'd2);
        checkOutput("run_lo_untouched", lo, 64'd3);
        op = OP_DIV; a = 32'hDEADBEEF; b = 32'd0;
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checkOutput("run_hi_after_pulse", hi, 64'd2);
        checkOutput("run_lo_after_pulse", lo, 64'd3);
        checkOutput("run_dbz_after_pulse", {63'b0, div_by_zero}, 64'd0);
        checkOutput("run_busy_after_pulse", {63'b0, busy}, 64'd1);
        waitIdle();

        @(negedge clk);
        a = 32'h1234; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checkOutput("mthi_idle", hi, 64'h1234);
        checkOutput("mtlo_idle", lo, 64'h1234);

        // start wins over mthi/mtlo on the same edge.
        issueOp(OP_DIVU, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0, 33, 1'b1);
        checkOutput("start_priority_hi", hi, 64'h1234);
        checkOutput("start_priority_lo", lo, 64'h1234);
        waitIdle();

        // Asynchronous reset in the middle of a multiply at count 10.
        issueOp(OP_MULT, 32'd5, 32'd9, 32'd0, 32'd45, 1'b0, 33, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
        checkOutput("midrst_done", {63'b0, done}, 64'd0);
        checkOutput("midrst_hi", hi, 64'd0);
        checkOutput("midrst_lo", lo, 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
